mul_share_arbiter: RTL

- Shares one `multiplication` instance (BF16/INT8, registered, fixed latency) between N requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, at most one issue per cycle, and each requester may have one operation outstanding.
- The block tracks in-flight operations with a latency-matched tag pipeline and routes each result back to its owner.

---
 rtl/mul_share_arbiter_if.sv | 41 ++++
 rtl/mul_share_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mul_share_arbiter_if
// Description : Bundle of the requester request/response channels and the
//               shared-multiplier operand/result bus seen by the arbiter.
//               slave  = arbiter side, master = requesters + multiplier side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_share_arbiter_if #(
    parameter int N = 4
);
    // Request channel, one lane per requester
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic [N-1:0]    req_int8;

    // Response channel, one lane per requester
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [16*N-1:0] rsp_res;

    // Shared multiplier bus
    logic [15:0]     mul_a;
    logic [15:0]     mul_b;
    logic            mul_int8;
    logic [15:0]     mul_res;

    modport slave (
        input  req_valid, req_a, req_b, req_int8, rsp_ready, mul_res,
        output req_ready, rsp_valid, rsp_res, mul_a, mul_b, mul_int8
    );

    modport master (
        output req_valid, req_a, req_b, req_int8, rsp_ready, mul_res,
        input  req_ready, rsp_valid, rsp_res, mul_a, mul_b, mul_int8
    );
endinterface
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mul_share_arbiter
// Description : Shares one fixed-latency registered multiplier between N
//               requesters. Round-robin issue (one op per cycle), one op
//               outstanding per requester, latency-matched {valid,id} tag
//               pipeline routes each result into its owner's hold register.
//               Optional macro MUL_SHARE_ARBITER_FIXED_PRIO_EN selects fixed
//               priority (lowest eligible index wins, no RR pointer).
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_arbiter #(
    parameter int N       = 4,   // number of requesters (2..8)
    parameter int MUL_LAT = 2,   // operand update -> valid mul_res (>=1)
    parameter int IDW     = 2    // requester-id width, >= clog2(N)
) (
    input wire                 clk,
    input wire                 rst,   // asynchronous, active-low
    mul_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INFLIGHT = 2'd1,
        S_DONE     = 2'd2
    } slot_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                run_q;
    logic [N-1:0]        w_idle;
    logic [N-1:0]        w_done;
    logic [N-1:0]        w_elig;
    logic [N-1:0]        w_grant_oh;
    logic [16*N-1:0]     w_res;
    logic                w_grant_vld;
    logic [IDW-1:0]      w_grant_id;

    logic [15:0]         w_sel_a;
    logic [15:0]         w_sel_b;
    logic                w_sel_int8;
    logic [15:0]         mul_a_q;
    logic [15:0]         mul_b_q;
    logic                mul_int8_q;

    logic [MUL_LAT:0]    tag_v_q;
    logic [IDW-1:0]      tag_id_q [MUL_LAT+1];
    logic                w_exit_v;
    logic [IDW-1:0]      w_exit_id;

`ifndef MUL_SHARE_ARBITER_FIXED_PRIO_EN
    localparam logic [IDW:0] c_N = (IDW+1)'(N);
    logic [IDW-1:0]          ptr_q;
    logic [IDW-1:0]          ptr_d;
    logic [IDW:0]            w_cand;
    logic [(1<<IDW)-1:0]     w_elig_pad;
`endif

    // Holds off grants while in reset and for the first edge after release,
    // so req_ready is guaranteed low during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // A requester competes only when it has a request and no op in any state.
    assign w_elig = bus.req_valid & w_idle & {N{run_q}};

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef MUL_SHARE_ARBITER_FIXED_PRIO_EN
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_grant_vld && w_elig[k]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = IDW'(k);
            end
        end
    end
`else
    // Zero-extend eligibility so any IDW-bit candidate index is in range.
    always_comb begin
        w_elig_pad        = '0;
        w_elig_pad[N-1:0] = w_elig;
    end

    // Round-robin: first eligible index at or after the pointer, wrapping.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_cand      = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (w_cand >= c_N) begin
                w_cand = w_cand - c_N;
            end
            if (!w_grant_vld && w_elig_pad[w_cand[IDW-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_cand[IDW-1:0];
            end
        end
    end

    // Pointer moves to the index after the winner; holds when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (w_grant_vld) begin
            ptr_d = (w_grant_id == IDW'(N-1)) ? '0 : w_grant_id + IDW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Decode the winner to a one-hot ready vector.
    always_comb begin
        w_grant_oh = '0;
        for (int k = 0; k < N; k++) begin
            w_grant_oh[k] = w_grant_vld && (w_grant_id == IDW'(k));
        end
    end

    // ------------------------------------------------------------------
    // Issue to the shared multiplier
    // ------------------------------------------------------------------
    // Select the granted requester's operands.
    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_int8 = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (w_grant_oh[k]) begin
                w_sel_a    = bus.req_a[16*k +: 16];
                w_sel_b    = bus.req_b[16*k +: 16];
                w_sel_int8 = bus.req_int8[k];
            end
        end
    end

    // Operand registers: loaded on a handshake, zeroed on idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_int8_q <= 1'b0;
        end else if (w_grant_vld) begin
            mul_a_q    <= w_sel_a;
            mul_b_q    <= w_sel_b;
            mul_int8_q <= w_sel_int8;
        end else begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_int8_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: stage 0 loads with the operands, the last stage lines
    // up with the cycle in which mul_res carries that op's product.
    // ------------------------------------------------------------------
    // Shift {valid,id} along MUL_LAT+1 stages; reset drops all in-flight ops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v_q <= '0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_v_q     <= {tag_v_q[MUL_LAT-1:0], w_grant_vld};
            tag_id_q[0] <= w_grant_id;
            for (int k = 1; k <= MUL_LAT; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    assign w_exit_v  = tag_v_q[MUL_LAT];
    assign w_exit_id = tag_id_q[MUL_LAT];

    // ------------------------------------------------------------------
    // Per-requester slots
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_slot
        slot_t       st_q;
        logic [15:0] res_q;

        // Slot lifecycle; the result register only loads on tag exit, so it
        // is frozen for the whole time the slot sits in DONE.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st_q  <= S_IDLE;
                res_q <= '0;
            end else begin
                case (st_q)
                    S_IDLE: begin
                        if (w_grant_oh[i]) begin
                            st_q <= S_INFLIGHT;
                        end
                    end
                    S_INFLIGHT: begin
                        if (w_exit_v && (w_exit_id == IDW'(i))) begin
                            st_q  <= S_DONE;
                            res_q <= bus.mul_res;
                        end
                    end
                    S_DONE: begin
                        if (bus.rsp_ready[i]) begin
                            st_q <= S_IDLE;
                        end
                    end
                    default: st_q <= S_IDLE;
                endcase
            end
        end

        assign w_idle[i]          = (st_q == S_IDLE);
        assign w_done[i]          = (st_q == S_DONE);
        assign w_res[16*i +: 16]  = res_q;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = w_grant_oh;
    assign bus.rsp_valid = w_done;
    assign bus.rsp_res   = w_res;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_int8  = mul_int8_q;

endmodule
`default_nettype wire
